// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency, single-port memory between the
// IF-stage fetch port and the MEM-stage load/store port. Data accesses win
// arbitration, but a starvation counter stops them from locking fetch out
// indefinitely. One access is in flight at a time. Each access finishes with a
// one-cycle acknowledge to the port that was granted.
module mem_arbiter #(
  parameter int DWIDTH = 32,
  parameter int LAT    = 2,
  parameter int STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              i_req,
  input  logic [DWIDTH-1:0] i_addr,
  output logic [DWIDTH-1:0] i_rdata,
  output logic              i_ack,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              d_ack,
  // memory side
  output logic              m_req,
  output logic              m_we,
  output logic [DWIDTH-1:0] m_addr,
  output logic [DWIDTH-1:0] m_wdata,
  input  logic [DWIDTH-1:0] m_rdata,
  // pipeline stall levels
  output logic              if_stall,
  output logic              mem_stall
);

  localparam int CW = $clog2(LAT + 1);
  localparam int SW = $clog2(STARVE + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic {G_I, G_D} gnt_t;

  state_t            state_q, state_d;
  gnt_t              gnt_q, gnt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic [DWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [DWIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DWIDTH-1:0] d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;

  logic              issue;
  logic              pick_d;
  logic              issue_we;

  // Next-state, arbitration and memory-strobe logic.
  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    scnt_d    = scnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    issue     = 1'b0;
    pick_d    = 1'b0;
    issue_we  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          issue    = 1'b1;
          // Data wins unless fetch has already waited through STARVE data grants.
          pick_d   = d_req && !(i_req && (scnt_q == SW'(STARVE)));
          issue_we = pick_d && d_we;
          gnt_d    = pick_d ? G_D : G_I;
          addr_d   = pick_d ? d_addr : i_addr;
          if (pick_d) begin
            wdata_d = d_wdata;
          end
          scnt_d = (pick_d && i_req) ? scnt_q + SW'(1) : '0;
          if (issue_we) begin
            // The memory commits the store at this edge, so it can be acknowledged next.
            state_d = S_DONE;
            d_ack_d = 1'b1;
          end else begin
            cnt_d   = CW'(LAT);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          if (gnt_q == G_D) begin
            d_rdata_d = m_rdata;
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = m_rdata;
            i_ack_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        // The requester still holds req this cycle, so no new issue is allowed.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory strobes come straight from the issue decision; the address and
  // write data fall back to the latched values outside the issuing cycle.
  assign m_req   = issue && !rst;
  assign m_we    = issue_we && !rst;
  assign m_addr  = addr_d;
  assign m_wdata = wdata_d;

  // Acks and stalls are suppressed while reset is asserted so an access cut
  // short by reset is never reported as complete.
  assign i_ack     = i_ack_q && !rst;
  assign d_ack     = d_ack_q && !rst;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = !rst && i_req && !i_ack;
  assign mem_stall = !rst && d_req && !d_ack;

  // State and datapath registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= G_I;
      cnt_q     <= '0;
      scnt_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      scnt_q    <= scnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives the fetch and load/store ports, emulates the memory
// with a LAT-deep read pipeline, and checks the arbiter against a
// transaction-level reference model. The model predicts every issue and
// completion. Its expectations go into a queue that a separate monitor drains.
module tb_mem_arbiter;

  localparam int DW     = 32;
  localparam int LAT    = 2;
  localparam int STARVE = 2;

  bit          clk;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        i_ack, d_ack, m_req, m_we, if_stall, mem_stall;

  mem_arbiter #(.DWIDTH(DW), .LAT(LAT), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .if_stall(if_stall), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory emulation ----------------
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        rd_v [LAT];
  logic [31:0] rd_d [LAT];
  logic [31:0] junk;

  always @(posedge clk) begin
    junk <= $urandom();
    if (m_req && m_we) mem[m_addr[7:0]] <= m_wdata;
    rd_v[0] <= m_req && !m_we;
    rd_d[0] <= mem[m_addr[7:0]];
    for (int i = 1; i < LAT; i++) begin
      rd_v[i] <= rd_v[i-1];
      rd_d[i] <= rd_d[i-1];
    end
  end

  // Read data is only meaningful exactly LAT cycles after the issue; junk otherwise.
  assign m_rdata = rd_v[LAT-1] ? rd_d[LAT-1] : junk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        is_d;
    logic        we;
    logic [31:0] data;
    int          ack_cyc;
  } exp_t;

  exp_t exp_q[$];
  bit   ack_log[$];
  int   free_at       = 0;
  int   scnt_m        = 0;
  int   exp_i_ack_cyc = -1;
  int   exp_d_ack_cyc = -1;

  // Predicts, once per cycle, whether an access issues and when it completes.
  always @(negedge clk) begin
    exp_t e;
    bit   take_d;
    if (rst) begin
      check("rst_m_req", m_req, 0);
      check("rst_m_we", m_we, 0);
      check("rst_if_stall", if_stall, 0);
      check("rst_mem_stall", mem_stall, 0);
      exp_q.delete();
      free_at       = cyc + 1;
      scnt_m        = 0;
      exp_i_ack_cyc = -1;
      exp_d_ack_cyc = -1;
    end else begin
      if (cyc >= free_at && (i_req || d_req)) begin
        take_d    = d_req && !(i_req && scnt_m == STARVE);
        e.is_d    = take_d;
        e.we      = take_d && d_we;
        e.ack_cyc = cyc + (e.we ? 1 : LAT + 1);
        e.data    = take_d ? ref_mem[d_addr[7:0]] : ref_mem[i_addr[7:0]];
        free_at   = e.ack_cyc + 1;
        scnt_m    = (take_d && i_req) ? scnt_m + 1 : 0;
        if (take_d) exp_d_ack_cyc = e.ack_cyc;
        else        exp_i_ack_cyc = e.ack_cyc;
        check("issue_m_req", m_req, 1);
        check("issue_m_we", m_we, e.we);
        check("issue_m_addr", m_addr, take_d ? d_addr : i_addr);
        if (e.we) begin
          check("issue_m_wdata", m_wdata, d_wdata);
          ref_mem[d_addr[7:0]] = d_wdata;
        end
        exp_q.push_back(e);
      end else begin
        check("idle_m_req", m_req, 0);
        check("idle_m_we", m_we, 0);
      end
      check("if_stall", if_stall, i_req && (exp_i_ack_cyc != cyc));
      check("mem_stall", mem_stall, d_req && (exp_d_ack_cyc != cyc));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] exp_i_rd, exp_d_rd;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("rst_i_ack", i_ack, 0);
      check("rst_d_ack", d_ack, 0);
      exp_i_rd = '0;
      exp_d_rd = '0;
    end else begin
      if (i_ack || d_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {30'd0, i_ack, d_ack}, 0);
        end else begin
          e = exp_q.pop_front();
          check("ack_port_i", i_ack, !e.is_d);
          check("ack_port_d", d_ack, e.is_d);
          check("ack_cycle", cyc, e.ack_cyc);
          if (!e.we) begin
            if (e.is_d) exp_d_rd = e.data;
            else        exp_i_rd = e.data;
          end
          ack_log.push_back(d_ack);
        end
      end
      while (exp_q.size() > 0 && exp_q[0].ack_cyc < cyc) begin
        check("missing_ack_cycle", cyc, exp_q[0].ack_cyc);
        void'(exp_q.pop_front());
      end
      check("i_rdata", i_rdata, exp_i_rd);
      check("d_rdata", d_rdata, exp_d_rd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic fetch_txn(input logic [31:0] a);
    bit got = 0;
    i_req  = 1'b1;
    i_addr = a;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (i_ack) begin
        got = 1;
        break;
      end
    end
    check("fetch_completed", 32'(got), 1);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bit got = 0;
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (d_ack) begin
        got = 1;
        break;
      end
    end
    check("data_completed", 32'(got), 1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bit [8:0]    pat;
    logic [31:0] a;
    int          seen;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom();
      ref_mem[i] = mem[i];
    end
    mem[8'h10]     = 32'hDEADBEEF;
    ref_mem[8'h10] = 32'hDEADBEEF;
    for (int i = 0; i < LAT; i++) begin
      rd_v[i] = 1'b0;
      rd_d[i] = '0;
    end

    // Reset with both ports requesting: nothing issues, data wins on release.
    rst = 1'b1; i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ack_log.delete();
    fork
      fetch_txn(32'h10);
      data_txn(1'b0, 32'h40, '0);
    join
    check("contention_count", ack_log.size(), 2);
    check("contention_first_is_d", 32'(ack_log[0]), 1);
    check("contention_second_is_i", 32'(ack_log[1]), 0);

    // Lone fetch.
    gap(2);
    fetch_txn(32'h10);
    check("lone_fetch_data", i_rdata, 32'hDEADBEEF);

    // Store leaves d_rdata untouched.
    gap(1);
    data_txn(1'b1, 32'h20, 32'h55);
    check("store_keeps_d_rdata", d_rdata, ref_mem[8'h40]);
    check("store_committed", mem[8'h20], 32'h55);

    // Starvation guard: D, D, I repeating.
    gap(1);
    ack_log.delete();
    fork
      repeat (3) fetch_txn($urandom());
      repeat (6) data_txn(1'b0, $urandom(), $urandom());
    join
    pat = 9'b110_110_110;
    check("starve_count", ack_log.size(), 9);
    for (int k = 0; k < 9 && k < ack_log.size(); k++)
      check("starve_order", 32'(ack_log[k]), 32'(pat[8-k]));

    // Randomised traffic on both ports.
    fork
      for (int n = 0; n < 60; n++) begin
        gap($urandom_range(0, 3));
        fetch_txn($urandom());
      end
      for (int n = 0; n < 60; n++) begin
        gap($urandom_range(0, 3));
        data_txn(1'($urandom_range(0, 1)), $urandom(), $urandom());
      end
    join

    // Reset in the middle of a load: no ack, then a clean fetch.
    gap(1);
    d_req = 1'b1; d_we = 1'b0; d_addr = $urandom();
    @(posedge clk); #1;
    rst = 1'b1; d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (d_ack) seen++;
    end
    check("no_ack_after_reset", seen, 0);
    @(posedge clk); #1;
    a = $urandom();
    fetch_txn(a);
    check("fetch_after_reset", i_rdata, ref_mem[a[7:0]]);

    gap(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port of the 5-stage pipeline. Sequences each access through a fixed-latency memory and returns read data with a one-cycle acknowledge. Exports per-port stall levels that hazard_ctrl turns into C_STALL for the affected stages. Data accesses have priority, and a starvation guard bounds how long fetch can wait.

## Interface
- DWIDTH, 32, data and address width
- LAT, 2, memory read latency in cycles (≥1)
- STARVE, 4, consecutive data grants allowed while fetch waits (≥1)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  DWIDTH  fetch address; stable while i_req
- i_rdata  out  DWIDTH  fetch data, registered, valid when i_ack
- i_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  DWIDTH  data address
- d_wdata  in  DWIDTH  store data
- d_rdata  out  DWIDTH  load data, registered, valid when d_ack
- d_ack  out  1  one-cycle data completion pulse
- m_req  out  1  memory access strobe, sampled by memory at posedge
- m_we  out  1  memory write enable, qualified by m_req
- m_addr  out  DWIDTH  memory address
- m_wdata  out  DWIDTH  memory write data
- m_rdata  in  DWIDTH  memory read data, valid exactly LAT cycles after the issuing cycle
- if_stall  out  1  i_req & ~i_ack
- mem_stall  out  1  d_req & ~d_ack

## Operation
- States: IDLE, WAIT, DONE. Grant register gnt ∈ {I, D}. Latency counter cnt, width clog2(LAT+1). Starvation counter scnt, width clog2(STARVE+1).
- IDLE: if i_req | d_req, issue. m_req=1 combinationally. m_we, m_addr and m_wdata come from the granted port. gnt, address and write data are latched.
  - Load issue: cnt←LAT, go to WAIT.
  - Store issue: go to DONE. Memory commits the write at the issuing edge.
  - No request: stay in IDLE, m_req=0.
- Arbitration in IDLE:
  - Grant D if d_req and not (i_req and scnt==STARVE); otherwise grant I if i_req.
  - Grant D while i_req=1: scnt←scnt+1.
  - Grant D while i_req=0, or grant I: scnt←0.
- WAIT: m_req=0. cnt decrements each cycle.
  - On the cycle cnt==1, capture m_rdata into i_rdata or d_rdata (per gnt) and go to DONE.
- DONE: assert i_ack or d_ack (per gnt) for exactly one cycle. m_req=0 and no new issue, because the requester's req is still high this cycle. Next state IDLE.
- m_addr/m_wdata hold the latched values outside the issuing cycle. m_we=0 whenever m_req=0.
- Store completion leaves d_rdata unchanged.
- Stalls are combinational from req and ack. Both are forced to 0 while rst=1.

## Timing
- Reset values: state IDLE, gnt I, cnt 0, scnt 0, i_rdata 0, d_rdata 0, i_ack 0, d_ack 0, latched address/data 0. m_req, m_we, if_stall and mem_stall are all 0 while rst=1.
- Load issued in cycle T: data captured at the end of cycle T+LAT, ack in cycle T+LAT+1, IDLE in cycle T+LAT+2. The earliest next issue is in cycle T+LAT+2.
- Store issued in cycle T: ack in cycle T+1, next issue in cycle T+2.
- Throughput: one load per LAT+2 cycles, one store per 2 cycles.
- Simultaneous i_req and d_req with scnt<STARVE: D is served first. I issues in the IDLE cycle after d_ack.
- A request raised during WAIT or DONE waits for IDLE. Its stall is high throughout.
- Reset mid-access (WAIT or DONE): return to IDLE next cycle. No ack is produced, and the in-flight m_rdata is discarded.
- A requester dropping req before its ack is illegal. Behaviour is unspecified beyond the ack being issued to the latched gnt.

## Test plan
- Reset: rst=1 for 2 cycles with i_req=d_req=1 → m_req=0, i_ack=d_ack=0, if_stall=mem_stall=0, i_rdata=d_rdata=0. After release, D issues in the first cycle.
- Lone fetch, LAT=2: i_req=1, i_addr=0x10 in cycle 0; memory drives 0xDEADBEEF in cycle 2 → m_req=1 with m_addr=0x10 in cycle 0 only, i_ack=1 with i_rdata=0xDEADBEEF in cycle 3, if_stall=1 in cycles 0–2.
- Contention, LAT=2: i_req (0x10) and d_req load (0x40) both in cycle 0 → cycle 0 m_addr=0x40, d_ack in cycle 3, I issues in cycle 4 with m_addr=0x10, i_ack in cycle 7.
- Store: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x55 in cycle 0 → m_req=m_we=1 with m_wdata=0x55 in cycle 0, d_ack in cycle 1, d_rdata unchanged.
- Starvation, STARVE=2: i_req held high, d_req reissued after every ack → grant order D, D, I, D, D, I. scnt returns to 0 after each I grant.
- Reset mid-load: load issued in cycle 0, rst=1 in cycle 1 → no d_ack in cycles 2–4. A fresh fetch issued after reset completes normally with correct data.
